// File: rtl/rooth_pipe_stage.sv
// Pipeline boundary register with a valid/ready handshake and an optional 2-entry skid buffer.
// With SKID_EN=1 the upstream ready is a flop, so the stage breaks the ready path from downstream.
// Flush drops everything in flight. A saturating counter tracks cycles of downstream back-pressure.
module rooth_pipe_stage #(
   parameter int PAYLOAD_W = 64,
   parameter int SKID_EN   = 1,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush_i,
   input  logic                 up_valid_i,
   output logic                 up_ready_o,
   input  logic [PAYLOAD_W-1:0] up_data_i,
   output logic                 dn_valid_o,
   input  logic                 dn_ready_i,
   output logic [PAYLOAD_W-1:0] dn_data_o,
   output logic [CNT_W-1:0]     stall_cnt_o
);

   // Bit 0 = main entry valid, bit 1 = skid entry valid, so both flags come straight from flops.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL  = 2'b01,
      ST_SKID  = 2'b11
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   w_load_main;
   logic                   w_load_skid;
   logic                   w_skid_to_main;
   logic [PAYLOAD_W-1:0]   r_main_data;
   logic [PAYLOAD_W-1:0]   r_skid_data;
   logic [CNT_W-1:0]       r_stall_cnt;

   // Upstream ready: registered skid flag when buffered, otherwise room-or-draining.
   always_comb begin
      if (SKID_EN != 0) begin
         up_ready_o = ~r_state[1];
      end else begin
         up_ready_o = ~r_state[0] | dn_ready_i;
      end
   end

   assign dn_valid_o  = r_state[0];
   assign dn_data_o   = r_main_data;
   assign stall_cnt_o = r_stall_cnt;

   // Next-state and datapath load selects; flush overrides every other event.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_state_nxt    = r_state;
      w_load_main    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_main = 1'b0;
      if (flush_i) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         unique case (r_state)
            ST_EMPTY: begin
               if (up_valid_i) begin
                  w_load_main = 1'b1;
                  w_state_nxt = ST_FULL;
               end
            end
            ST_FULL: begin
               if (dn_ready_i && up_valid_i) begin
                  w_load_main = 1'b1;
               end else if (dn_ready_i) begin
                  w_state_nxt = ST_EMPTY;
               end else if (up_valid_i && (SKID_EN != 0)) begin
                  w_load_skid = 1'b1;
                  w_state_nxt = ST_SKID;
               end
            end
            ST_SKID: begin
               if (dn_ready_i) begin
                  w_skid_to_main = 1'b1;
                  w_state_nxt    = ST_FULL;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Payload registers: zeroed by reset and flush, otherwise hold unless loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: payload registers are reset because a zero output after reset/flush is visible behaviour.
      if (!rst_n) begin
         r_main_data <= '0;
         r_skid_data <= '0;
      end else if (flush_i) begin
         r_main_data <= '0;
         r_skid_data <= '0;
      end else begin
         if (w_load_main) begin
            r_main_data <= up_data_i;
         end else if (w_skid_to_main) begin
            r_main_data <= r_skid_data;
         end
         if (w_load_skid) begin
            r_skid_data <= up_data_i;
         end
      end
   end

   // Saturating back-pressure counter; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (r_state[0] && !dn_ready_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_rooth_pipe_stage.sv
// Bench for rooth_pipe_stage: three instances share one stimulus stream
// (0: skid, 16-bit counter; 1: no skid; 2: skid, 4-bit counter) and are
// compared against a FIFO-occupancy reference model.
module tb_rooth_pipe_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        up_valid;
   logic [63:0] up_data;
   logic        dn_ready;

   logic        a_up_ready, b_up_ready, c_up_ready;
   logic        a_dn_valid, b_dn_valid, c_dn_valid;
   logic [63:0] a_dn_data, b_dn_data, c_dn_data;
   logic [15:0] a_stall, b_stall;
   logic [3:0]  c_stall;

   logic        obs_ready [3];
   logic        obs_valid [3];
   logic [63:0] obs_data  [3];
   logic [31:0] obs_stall [3];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: per instance a small ordered buffer with an occupancy count.
   int          m_cnt   [3];
   logic [63:0] m_buf   [3][2];
   logic [63:0] m_last  [3];
   int          m_stall [3];
   bit          m_skid  [3] = '{1'b1, 1'b0, 1'b1};
   int          m_max   [3] = '{65535, 65535, 15};

   rooth_pipe_stage #(.PAYLOAD_W(64), .SKID_EN(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .up_valid_i(up_valid), .up_ready_o(a_up_ready),
      .up_data_i(up_data), .dn_valid_o(a_dn_valid), .dn_ready_i(dn_ready), .dn_data_o(a_dn_data),
      .stall_cnt_o(a_stall));
   rooth_pipe_stage #(.PAYLOAD_W(64), .SKID_EN(0), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .up_valid_i(up_valid), .up_ready_o(b_up_ready),
      .up_data_i(up_data), .dn_valid_o(b_dn_valid), .dn_ready_i(dn_ready), .dn_data_o(b_dn_data),
      .stall_cnt_o(b_stall));
   rooth_pipe_stage #(.PAYLOAD_W(64), .SKID_EN(1), .CNT_W(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .up_valid_i(up_valid), .up_ready_o(c_up_ready),
      .up_data_i(up_data), .dn_valid_o(c_dn_valid), .dn_ready_i(dn_ready), .dn_data_o(c_dn_data),
      .stall_cnt_o(c_stall));

   assign obs_ready[0] = a_up_ready;
   assign obs_ready[1] = b_up_ready;
   assign obs_ready[2] = c_up_ready;
   assign obs_valid[0] = a_dn_valid;
   assign obs_valid[1] = b_dn_valid;
   assign obs_valid[2] = c_dn_valid;
   assign obs_data[0]  = a_dn_data;
   assign obs_data[1]  = b_dn_data;
   assign obs_data[2]  = c_dn_data;
   assign obs_stall[0] = 32'(a_stall);
   assign obs_stall[1] = 32'(b_stall);
   assign obs_stall[2] = 32'(c_stall);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit m_ready(int k);
      if (m_skid[k]) return m_cnt[k] < 2;
      return (m_cnt[k] == 0) || dn_ready;
   endfunction

   function automatic logic [63:0] m_data(int k);
      return (m_cnt[k] > 0) ? m_buf[k][0] : m_last[k];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_cnt[k]   = 0;
         m_last[k]  = '0;
         m_stall[k] = 0;
      end
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_update();
      bit rdy;
      bit vld;
      for (int k = 0; k < 3; k++) begin
         rdy = m_ready(k);
         vld = m_cnt[k] > 0;
         if (vld && !dn_ready && m_stall[k] < m_max[k]) m_stall[k]++;
         if (flush) begin
            m_cnt[k]  = 0;
            m_last[k] = '0;
         end else begin
            if (vld && dn_ready) begin
               m_last[k]   = m_buf[k][0];
               m_buf[k][0] = m_buf[k][1];
               m_cnt[k]--;
            end
            if (up_valid && rdy) begin
               m_buf[k][m_cnt[k]] = up_data;
               m_cnt[k]++;
            end
         end
      end
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic r, input logic f);
      up_valid = v;
      up_data  = d;
      dn_ready = r;
      flush    = f;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      model_reset();
      #12;
      n_tests++;
      if (a_up_ready !== 1'b1 || a_dn_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_a_hs: ready=%b valid=%b expected ready=1 valid=0", a_up_ready, a_dn_valid);
      end
      n_tests++;
      if (a_dn_data !== 64'h0 || a_stall !== 16'h0 || c_stall !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_a_data: data=%h stall=%0d c_stall=%0d expected 0/0/0", a_dn_data, a_stall, c_stall);
      end
      n_tests++;
      if (b_up_ready !== 1'b1 || b_dn_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_b_hs: ready=%b valid=%b expected ready=1 valid=0", b_up_ready, b_dn_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_stream();
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 64'(i), 1'b1, 1'b0);
         #1;
         n_tests++;
         if (a_up_ready !== 1'b1 || b_up_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_ready beat %0d: a=%b b=%b expected 1", i, a_up_ready, b_up_ready);
         end
         tick();
         n_tests++;
         if (a_dn_valid !== 1'b1 || a_dn_data !== 64'(i) || b_dn_valid !== 1'b1 || b_dn_data !== 64'(i)) begin
            n_fail++;
            $display("FAIL stream_out beat %0d: a=%b/%h b=%b/%h expected 1/%h", i, a_dn_valid, a_dn_data,
                     b_dn_valid, b_dn_data, 64'(i));
         end
      end
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      tick();
      n_tests++;
      if (a_dn_valid !== 1'b0 || a_dn_data !== 64'h8) begin
         n_fail++;
         $display("FAIL stream_drain: valid=%b data=%h expected 0/8", a_dn_valid, a_dn_data);
      end
   endtask

   task automatic test_skid();
      drive(1'b1, 64'hA, 1'b1, 1'b0);
      tick();
      drive(1'b1, 64'hB, 1'b0, 1'b0);
      #1;
      n_tests++;
      if (a_up_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL skid_ready_full: got %b expected 1", a_up_ready);
      end
      tick();
      n_tests++;
      if (a_up_ready !== 1'b0 || a_dn_valid !== 1'b1 || a_dn_data !== 64'hA) begin
         n_fail++;
         $display("FAIL skid_enter: ready=%b valid=%b data=%h expected 0/1/a", a_up_ready, a_dn_valid, a_dn_data);
      end
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      tick();
      n_tests++;
      if (a_dn_valid !== 1'b1 || a_dn_data !== 64'hB || a_up_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL skid_second: valid=%b data=%h ready=%b expected 1/b/1", a_dn_valid, a_dn_data, a_up_ready);
      end
      tick();
      n_tests++;
      if (a_dn_valid !== 1'b0 || a_stall !== 16'd1) begin
         n_fail++;
         $display("FAIL skid_stall: valid=%b stall=%0d expected 0/1", a_dn_valid, a_stall);
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 64'h10, 1'b1, 1'b0);
      tick();
      drive(1'b1, 64'h11, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'hC, 1'b0, 1'b1);
      tick();
      n_tests++;
      if (a_dn_valid !== 1'b0 || a_dn_data !== 64'h0 || a_up_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_out: valid=%b data=%h ready=%b expected 0/0/1", a_dn_valid, a_dn_data, a_up_ready);
      end
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (a_dn_valid !== 1'b0 || a_dn_data === 64'hC) begin
            n_fail++;
            $display("FAIL flush_dropped cyc %0d: valid=%b data=%h expected 0/00", i, a_dn_valid, a_dn_data);
         end
      end
   endtask

   task automatic test_saturate();
      drive(1'b1, 64'h20, 1'b0, 1'b0);
      for (int i = 0; i < 21; i++) begin
         tick();
         n_tests++;
         if (32'(c_stall) !== 32'(m_stall[2])) begin
            n_fail++;
            $display("FAIL sat_count cyc %0d: got %0d expected %0d", i, c_stall, m_stall[2]);
         end
      end
      n_tests++;
      if (c_stall !== 4'd15) begin
         n_fail++;
         $display("FAIL sat_max: got %0d expected 15", c_stall);
      end
      tick();
      tick();
      n_tests++;
      if (c_stall !== 4'd15 || a_stall !== 16'(m_stall[0])) begin
         n_fail++;
         $display("FAIL sat_hold: c=%0d a=%0d expected 15/%0d", c_stall, a_stall, m_stall[0]);
      end
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      tick();
      tick();
      tick();
   endtask

   task automatic test_no_skid();
      drive(1'b1, 64'h30, 1'b1, 1'b0);
      tick();
      drive(1'b1, 64'h31, 1'b0, 1'b0);
      #1;
      n_tests++;
      if (b_up_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL noskid_block: ready=%b expected 0", b_up_ready);
      end
      dn_ready = 1'b1;
      #1;
      n_tests++;
      if (b_up_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL noskid_ready: ready=%b expected 1", b_up_ready);
      end
      tick();
      n_tests++;
      if (b_dn_valid !== 1'b1 || b_dn_data !== 64'h31) begin
         n_fail++;
         $display("FAIL noskid_pass1: valid=%b data=%h expected 1/31", b_dn_valid, b_dn_data);
      end
      drive(1'b1, 64'h32, 1'b1, 1'b0);
      tick();
      n_tests++;
      if (b_dn_valid !== 1'b1 || b_dn_data !== 64'h32) begin
         n_fail++;
         $display("FAIL noskid_pass2: valid=%b data=%h expected 1/32", b_dn_valid, b_dn_data);
      end
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      tick();
      tick();
   endtask

   task automatic test_async_reset();
      drive(1'b1, 64'h40, 1'b1, 1'b0);
      tick();
      drive(1'b1, 64'h41, 1'b0, 1'b0);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (a_dn_valid !== 1'b0 || a_stall !== 16'h0 || a_dn_data !== 64'h0 || a_up_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: valid=%b stall=%0d data=%h ready=%b expected 0/0/0/1", a_dn_valid,
                  a_stall, a_dn_data, a_up_ready);
      end
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      drive(1'b1, 64'h50, 1'b1, 1'b0);
      tick();
      n_tests++;
      if (a_dn_valid !== 1'b1 || a_dn_data !== 64'h50 || b_dn_data !== 64'h50) begin
         n_fail++;
         $display("FAIL post_reset_beat: valid=%b a=%h b=%h expected 1/50/50", a_dn_valid, a_dn_data, b_dn_data);
      end
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         drive(1'($urandom_range(0, 9) < 7), {$urandom, $urandom}, 1'($urandom_range(0, 9) < 6),
               1'($urandom_range(0, 39) == 0));
         #1;
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_ready[k] !== m_ready(k) || obs_valid[k] !== (m_cnt[k] > 0) || obs_data[k] !== m_data(k)
                || obs_stall[k] !== 32'(m_stall[k])) begin
               n_fail++;
               $display("FAIL random cyc %0d dut %0d: rdy=%b vld=%b data=%h stall=%0d expected %b/%b/%h/%0d",
                        cyc, k, obs_ready[k], obs_valid[k], obs_data[k], obs_stall[k], m_ready(k),
                        m_cnt[k] > 0, m_data(k), m_stall[k]);
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_skid();
      test_flush();
      test_saturate();
      test_no_skid();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
